// File: rtl/local_store_sequencer.sv
// Sequencer driving a PE LocalStoreController: offset programming
// followed by an INCR/JUMP walk over one convolution window.
module local_store_sequencer #(
  parameter int depth = 2,
  parameter int LW    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stall,
  input  logic             peSel,
  input  logic [LW-1:0]    winRows,
  input  logic [LW-1:0]    winCols,
  input  logic [depth-1:0] kRowOfst,
  input  logic [depth-1:0] kColOfst,
  input  logic [depth-1:0] nRowOfst,
  input  logic [depth-1:0] nColOfst,
  output logic [5:0]       controlSignal,
  output logic [depth-1:0] initSettings,
  output logic             initPESelect,
  output logic             macValid,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] C_INIT = 3'b000;
  localparam logic [2:0] C_HOLD = 3'b001;
  localparam logic [2:0] C_INCR = 3'b010;
  localparam logic [2:0] C_JUMP = 3'b011;
  localparam logic [2:0] C_SKR  = 3'b100;
  localparam logic [2:0] C_SKC  = 3'b101;
  localparam logic [2:0] C_SNR  = 3'b110;
  localparam logic [2:0] C_SNC  = 3'b111;

  // step names the command issued at the next edge; the
  // outputs are loaded together with it, so they always show
  // the command the consumer sees in the current cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SKR,
    S_SKC,
    S_SNR,
    S_SNC,
    S_RUN,
    S_JUMP,
    S_DONE
  } step_t;

  step_t            step;
  logic [LW-1:0]    rows_q;
  logic [LW-1:0]    cols_q;
  logic [depth-1:0] kro_q;
  logic [depth-1:0] kco_q;
  logic [depth-1:0] nro_q;
  logic [depth-1:0] nco_q;
  logic             sel_q;
  logic [LW-1:0]    row;
  logic [LW-1:0]    col;

  logic last_col;
  logic last_row;
  logic empty;

  assign last_col = (col == cols_q - LW'(1));
  assign last_row = (row == rows_q - LW'(1));
  assign empty    = (rows_q == '0) || (cols_q == '0);

  // Sequencer FSM with registered command outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step          <= S_IDLE;
      controlSignal <= {C_HOLD, C_HOLD};
      initSettings  <= '0;
      initPESelect  <= 1'b0;
      macValid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rows_q        <= '0;
      cols_q        <= '0;
      kro_q         <= '0;
      kco_q         <= '0;
      nro_q         <= '0;
      nco_q         <= '0;
      sel_q         <= 1'b0;
      row           <= '0;
      col           <= '0;
    end else begin
      initSettings <= '0;
      initPESelect <= 1'b0;
      macValid     <= 1'b0;
      done         <= 1'b0;
      unique case (step)
        S_IDLE: begin
          controlSignal <= {C_HOLD, C_HOLD};
          busy          <= 1'b0;
          // done is high only in the DONE cycle: a start
          // there is dropped and taken a cycle later.
          if (start && !done) begin
            rows_q        <= winRows;
            cols_q        <= winCols;
            kro_q         <= kRowOfst;
            kco_q         <= kColOfst;
            nro_q         <= nRowOfst;
            nco_q         <= nColOfst;
            sel_q         <= peSel;
            row           <= '0;
            col           <= '0;
            controlSignal <= {C_INIT, C_INIT};
            busy          <= 1'b1;
            step          <= S_SKR;
          end
        end
        S_SKR: begin
          controlSignal <= {C_SKR, C_SKR};
          initSettings  <= kro_q;
          initPESelect  <= sel_q;
          step          <= S_SKC;
        end
        S_SKC: begin
          controlSignal <= {C_SKC, C_SKC};
          initSettings  <= kco_q;
          initPESelect  <= sel_q;
          step          <= S_SNR;
        end
        S_SNR: begin
          controlSignal <= {C_SNR, C_SNR};
          initSettings  <= nro_q;
          initPESelect  <= sel_q;
          step          <= S_SNC;
        end
        S_SNC: begin
          controlSignal <= {C_SNC, C_SNC};
          initSettings  <= nco_q;
          initPESelect  <= sel_q;
          step          <= empty ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            controlSignal <= {C_HOLD, C_HOLD};
          end else begin
            controlSignal <= {C_INCR, C_INCR};
            macValid      <= 1'b1;
            if (last_col) begin
              step <= last_row ? S_DONE : S_JUMP;
            end else begin
              col <= col + LW'(1);
            end
          end
        end
        S_JUMP: begin
          if (stall) begin
            controlSignal <= {C_HOLD, C_HOLD};
          end else begin
            controlSignal <= {C_JUMP, C_JUMP};
            row           <= row + LW'(1);
            col           <= '0;
            step          <= S_RUN;
          end
        end
        S_DONE: begin
          controlSignal <= {C_HOLD, C_HOLD};
          done          <= 1'b1;
          busy          <= 1'b0;
          step          <= S_IDLE;
        end
        default: begin
          controlSignal <= {C_HOLD, C_HOLD};
          busy          <= 1'b0;
          step          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_store_sequencer.sv
// Directed bench for local_store_sequencer with a small
// kernel-address model standing in for the PE.
module tb_local_store_sequencer;

  localparam logic [2:0] INIT = 3'b000;
  localparam logic [2:0] HOLD = 3'b001;
  localparam logic [2:0] INCR = 3'b010;
  localparam logic [2:0] JUMP = 3'b011;
  localparam logic [2:0] SKR  = 3'b100;
  localparam logic [2:0] SKC  = 3'b101;
  localparam logic [2:0] SNR  = 3'b110;
  localparam logic [2:0] SNC  = 3'b111;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic       stall;
  logic       peSel;
  logic [3:0] winRows;
  logic [3:0] winCols;
  logic [1:0] kRowOfst;
  logic [1:0] kColOfst;
  logic [1:0] nRowOfst;
  logic [1:0] nColOfst;
  logic [5:0] controlSignal;
  logic [1:0] initSettings;
  logic       initPESelect;
  logic       macValid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  int kr = 0;
  int kc = 0;
  int kcb = 0;
  int ncap = 0;
  int cap [64];

  local_store_sequencer #(.depth(2), .LW(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .start(start),
    .stall(stall),
    .peSel(peSel),
    .winRows(winRows),
    .winCols(winCols),
    .kRowOfst(kRowOfst),
    .kColOfst(kColOfst),
    .nRowOfst(nRowOfst),
    .nColOfst(nColOfst),
    .controlSignal(controlSignal),
    .initSettings(initSettings),
    .initPESelect(initPESelect),
    .macValid(macValid),
    .busy(busy),
    .done(done)
  );

  always #5 CLK = ~CLK;

  // Model PE kernel FSM: samples address then updates on negedge.
  always @(negedge CLK) begin
    if (macValid && ncap < 64) begin
      cap[ncap] = kr * 8 + kc;
      ncap++;
    end
    case (controlSignal[5:3])
      INIT: begin kr = 0; kc = 0; kcb = 0; end
      SKR:  if (initPESelect) kr = int'(initSettings);
      SKC:  if (initPESelect) begin
              kc  = int'(initSettings);
              kcb = int'(initSettings);
            end
      INCR: kc = kc + 1;
      JUMP: begin kr = kr + 1; kc = kcb; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic e(input string tag, input logic [2:0] c,
                   input logic [1:0] s, input logic p,
                   input logic m, input logic b, input logic d);
    logic [11:0] obs;
    logic [11:0] expv;
    obs  = {controlSignal, initSettings, initPESelect,
            macValid, busy, done};
    expv = {c, c, s, p, m, b, d};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cfg(input logic [3:0] r, input logic [3:0] c,
                     input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] x, input logic [1:0] y,
                     input logic sel);
    winRows  = r;
    winCols  = c;
    kRowOfst = a;
    kColOfst = b;
    nRowOfst = x;
    nColOfst = y;
    peSel    = sel;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg(4'hf, 4'hf, 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);
  endtask

  initial begin
    bit seen;
    RST_N = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    e("reset", HOLD, 2'd0, 0, 0, 0, 0);
    RST_N = 1'b1;
    tick();
    e("idle", HOLD, 2'd0, 0, 0, 0, 0);

    // 1: rows=2 cols=3
    cfg(4'd2, 4'd3, 2'd1, 2'd2, 2'd3, 2'd0, 1'b1);
    go();
    e("t1 init", INIT, 2'd0, 0, 0, 1, 0);
    tick(); e("t1 skr", SKR, 2'd1, 1, 0, 1, 0);
    tick(); e("t1 skc", SKC, 2'd2, 1, 0, 1, 0);
    tick(); e("t1 snr", SNR, 2'd3, 1, 0, 1, 0);
    tick(); e("t1 snc", SNC, 2'd0, 1, 0, 1, 0);
    tick(); e("t1 incr0", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 incr1", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 incr2", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 jump", JUMP, 2'd0, 0, 0, 1, 0);
    tick(); e("t1 incr3", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 incr4", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 incr5", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t1 done", HOLD, 2'd0, 0, 0, 0, 1);
    tick(); e("t1 idle", HOLD, 2'd0, 0, 0, 0, 0);

    // 2: empty window, then start held through DONE
    cfg(4'd0, 4'd5, 2'd3, 2'd1, 2'd2, 2'd3, 1'b1);
    go();
    e("t2 init", INIT, 2'd0, 0, 0, 1, 0);
    tick(); e("t2 skr", SKR, 2'd3, 1, 0, 1, 0);
    tick(); e("t2 skc", SKC, 2'd1, 1, 0, 1, 0);
    tick(); e("t2 snr", SNR, 2'd2, 1, 0, 1, 0);
    tick(); e("t2 snc", SNC, 2'd3, 1, 0, 1, 0);
    tick(); e("t2 done", HOLD, 2'd0, 0, 0, 0, 1);
    cfg(4'd0, 4'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1);
    start = 1'b1;
    tick(); e("t2 start in done", HOLD, 2'd0, 0, 0, 0, 0);
    tick(); e("t2 restart", INIT, 2'd0, 0, 0, 1, 0);
    start = 1'b0;
    tick(); e("t2b skr", SKR, 2'd2, 1, 0, 1, 0);
    tick(); tick(); tick();
    tick(); e("t2b done", HOLD, 2'd0, 0, 0, 0, 1);
    tick();

    // 3: stall for two cycles after the 2nd INCR
    cfg(4'd1, 4'd4, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    go();
    e("t3 init", INIT, 2'd0, 0, 0, 1, 0);
    tick(); tick(); tick();
    tick(); e("t3 snc", SNC, 2'd0, 1, 0, 1, 0);
    tick(); e("t3 incr0", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t3 incr1", INCR, 2'd0, 0, 1, 1, 0);
    stall = 1'b1;
    tick(); e("t3 hold0", HOLD, 2'd0, 0, 0, 1, 0);
    tick(); e("t3 hold1", HOLD, 2'd0, 0, 0, 1, 0);
    stall = 1'b0;
    tick(); e("t3 incr2", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t3 incr3", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t3 done", HOLD, 2'd0, 0, 0, 0, 1);
    tick();

    // 4: peSel=0, start pulsed while busy
    cfg(4'd1, 4'd1, 2'd2, 2'd1, 2'd3, 2'd1, 1'b0);
    go();
    e("t4 init", INIT, 2'd0, 0, 0, 1, 0);
    tick(); e("t4 skr", SKR, 2'd2, 0, 0, 1, 0);
    start = 1'b1;
    tick(); e("t4 skc", SKC, 2'd1, 0, 0, 1, 0);
    start = 1'b0;
    tick(); e("t4 snr", SNR, 2'd3, 0, 0, 1, 0);
    tick(); e("t4 snc", SNC, 2'd1, 0, 0, 1, 0);
    tick(); e("t4 incr", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t4 done", HOLD, 2'd0, 0, 0, 0, 1);
    tick(); e("t4 idle", HOLD, 2'd0, 0, 0, 0, 0);

    // 5: asynchronous reset during RUN
    cfg(4'd2, 4'd2, 2'd1, 2'd1, 2'd1, 2'd1, 1'b1);
    go();
    tick(); tick(); tick(); tick();
    tick(); e("t5 incr", INCR, 2'd0, 0, 1, 1, 0);
    #2 RST_N = 1'b0;
    #1 e("t5 async rst", HOLD, 2'd0, 0, 0, 0, 0);
    #2 RST_N = 1'b1;
    tick(); e("t5 idle", HOLD, 2'd0, 0, 0, 0, 0);
    cfg(4'd1, 4'd1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1);
    go();
    e("t5 init", INIT, 2'd0, 0, 0, 1, 0);
    tick(); e("t5 skr", SKR, 2'd1, 1, 0, 1, 0);
    tick(); tick(); tick();
    tick(); e("t5 incr2", INCR, 2'd0, 0, 1, 1, 0);
    tick(); e("t5 done", HOLD, 2'd0, 0, 0, 0, 1);
    tick();

    // 6: 4x4 window against the model PE, stall mid-walk
    ncap = 0;
    cfg(4'd4, 4'd4, 2'd1, 2'd2, 2'd0, 2'd3, 1'b1);
    go();
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      stall = (k == 8 || k == 9 || k == 15);
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    stall = 1'b0;
    chk("t6 done seen", int'(seen), 1);
    chk("t6 mac count", ncap, 16);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("t6 addr r%0d c%0d", r, c),
            cap[r * 4 + c], (r + 1) * 8 + c + 2);
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
